// File: rtl/replay_receiver_pkg.sv
// Shared types for the link replay receive path: sequence numbers and
// the receiver FSM encoding used alongside the transmitter replay buffer.
package replay_receiver_pkg;

  localparam int BUFFER_SIZE = 16;
  localparam int SEQ_WIDTH   = $clog2(BUFFER_SIZE);

  typedef logic [SEQ_WIDTH-1:0] SeqNum;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DROP  = 2'd2
  } ReplayRxState;

endpackage

// File: rtl/replay_receiver_ack_coalescer.sv
// Counts accepted packets and turns them into coalesced ack pulses, either
// when the pending count reaches the threshold, when the link has been idle
// long enough with packets outstanding, or when the receiver forces a flush
// ahead of a nack.
module replay_receiver_ack_coalescer #(
  parameter int seq_width     = 4,
  parameter int ack_threshold = 4,
  parameter int ack_timeout   = 32
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 accept,
  input  logic                 force_flush,
  input  logic                 clear,
  output logic                 ack,
  output logic [seq_width-1:0] ack_count,
  output logic                 pend_nonzero
);

  localparam int TW = $clog2(ack_timeout + 1);
  localparam logic [seq_width-1:0] THRESHOLD = seq_width'(ack_threshold);
  localparam logic [TW-1:0]        IDLE_LAST = TW'(ack_timeout - 1);

  logic [seq_width-1:0] pend;
  logic [seq_width-1:0] pend_next;
  logic [TW-1:0]        idle_timer;
  logic                 fire;

  // Post-accept pending count and whether this cycle closes out an ack
  always_comb begin
    pend_next = pend + seq_width'(accept);
    fire      = 1'b0;
    if (clear) begin
      fire = 1'b0;
    end else if (force_flush) begin
      fire = 1'b1;
    end else if (accept) begin
      fire = (pend_next == THRESHOLD);
    end else begin
      fire = (pend != '0) && (idle_timer == IDLE_LAST);
    end
  end

  // Pending count, idle timer and the registered ack pulse with its count
  always_ff @(posedge clk) begin
    if (nreset) begin
      pend       <= '0;
      idle_timer <= '0;
      ack        <= 1'b0;
      ack_count  <= '0;
    end else begin
      ack       <= fire;
      ack_count <= fire ? pend_next : '0;
      pend      <= (fire || clear) ? '0 : pend_next;
      if (fire || clear || accept || (pend == '0)) begin
        idle_timer <= '0;
      end else begin
        idle_timer <= idle_timer + TW'(1);
      end
    end
  end

  assign pend_nonzero = (pend != '0);

endmodule

// File: rtl/replay_receiver.sv
// Receive side of the link replay protocol. Forwards only in-order,
// error-free packets through a one-entry output register, and tells the
// transmitter what arrived (coalesced acks) or that it must rewind (nacks).
module replay_receiver
  import replay_receiver_pkg::*;
#(
  parameter int buffer_size   = BUFFER_SIZE,
  parameter int packet_width  = 64,
  parameter int ack_threshold = 4,
  parameter int ack_timeout   = 32,
  parameter int nack_timeout  = 64
) (
  input  logic                           clk,
  input  logic                           nreset,
  input  logic                           rx_valid,
  input  logic [$clog2(buffer_size)-1:0] rx_seq,
  input  logic                           rx_error,
  input  logic [packet_width-1:0]        rx_packet,
  output logic                           out_valid,
  output logic [packet_width-1:0]        out_packet,
  input  logic                           out_ready,
  output logic                           ack,
  output logic [$clog2(buffer_size)-1:0] ack_count,
  output logic                           nack
);

  localparam int SW  = $clog2(buffer_size);
  localparam int NTW = $clog2(nack_timeout + 1);
  localparam logic [NTW-1:0] NACK_LAST = NTW'(nack_timeout - 1);

  ReplayRxState   state;
  ReplayRxState   next_state;
  logic [SW-1:0]  exp_seq;
  logic [NTW-1:0] nack_timer;
  logic [NTW-1:0] nack_timer_next;
  logic           nack_next;
  logic           slot_free;
  logic           good;
  logic           accept;
  logic           force_flush;
  logic           clear_pend;
  logic           pend_nonzero;

  // A full output register that is not draining is treated like a bad
  // sequence number, since there is no backpressure toward the link.
  assign slot_free = !out_valid || out_ready;
  assign good      = rx_valid && !rx_error && (rx_seq == exp_seq) && slot_free;

  // The flush ack has already emptied the pending count; holding clear in
  // FLUSH keeps the coalescer parked while the nack goes out.
  assign clear_pend = (state == FLUSH);

  // Next state, accept decision and nack generation
  always_comb begin
    next_state      = state;
    accept          = 1'b0;
    force_flush     = 1'b0;
    nack_next       = 1'b0;
    nack_timer_next = '0;
    case (state)
      RUN: begin
        if (good) begin
          accept = 1'b1;
        end else if (rx_valid) begin
          if (pend_nonzero) begin
            force_flush = 1'b1;
            next_state  = FLUSH;
          end else begin
            nack_next  = 1'b1;
            next_state = DROP;
          end
        end
      end
      FLUSH: begin
        nack_next  = 1'b1;
        next_state = DROP;
      end
      DROP: begin
        if (good) begin
          accept     = 1'b1;
          next_state = RUN;
        end else if (nack_timer == NACK_LAST) begin
          nack_next = 1'b1;
        end else begin
          nack_timer_next = nack_timer + NTW'(1);
        end
      end
      default: begin
        next_state = RUN;
      end
    endcase
  end

  // FSM state, expected sequence number, nack timer and nack pulse
  always_ff @(posedge clk) begin
    if (nreset) begin
      state      <= RUN;
      exp_seq    <= '0;
      nack_timer <= '0;
      nack       <= 1'b0;
    end else begin
      state      <= next_state;
      nack_timer <= nack_timer_next;
      nack       <= nack_next;
      if (accept) begin
        exp_seq <= exp_seq + SW'(1);
      end
    end
  end

  // One-entry output register: load on accept, empty when drained
  always_ff @(posedge clk) begin
    if (nreset) begin
      out_valid  <= 1'b0;
      out_packet <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_packet <= rx_packet;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  replay_receiver_ack_coalescer #(
    .seq_width     (SW),
    .ack_threshold (ack_threshold),
    .ack_timeout   (ack_timeout)
  ) u_ack_coalescer (
    .clk          (clk),
    .nreset       (nreset),
    .accept       (accept),
    .force_flush  (force_flush),
    .clear        (clear_pend),
    .ack          (ack),
    .ack_count    (ack_count),
    .pend_nonzero (pend_nonzero)
  );

endmodule

// File: tb/tb_replay_receiver.sv
// Testbench for replay_receiver: each scenario drives packets one cycle at a
// time and queues the packets and ack/nack pulses it expects, keyed by the
// cycle they must appear in; every cycle the queues are compared with the DUT.
module tb_replay_receiver;
  import replay_receiver_pkg::*;

  localparam int PW = 64;

  typedef struct {
    int          cyc;
    logic [PW-1:0] data;
  } pkt_exp_t;

  typedef struct {
    int    cyc;
    logic  is_ack;
    SeqNum cnt;
  } hs_exp_t;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          rx_valid = 1'b0;
  SeqNum         rx_seq = '0;
  logic          rx_error = 1'b0;
  logic [PW-1:0] rx_packet = '0;
  logic          out_valid;
  logic [PW-1:0] out_packet;
  logic          out_ready = 1'b1;
  logic          ack;
  SeqNum         ack_count;
  logic          nack;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  pkt_exp_t      pkt_q[$];
  hs_exp_t       hs_q[$];
  logic          mon_v = 1'b0;
  logic [PW-1:0] mon_d = '0;

  replay_receiver #(
    .buffer_size   (16),
    .packet_width  (PW),
    .ack_threshold (4),
    .ack_timeout   (32),
    .nack_timeout  (64)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .rx_valid   (rx_valid),
    .rx_seq     (rx_seq),
    .rx_error   (rx_error),
    .rx_packet  (rx_packet),
    .out_valid  (out_valid),
    .out_packet (out_packet),
    .out_ready  (out_ready),
    .ack        (ack),
    .ack_count  (ack_count),
    .nack       (nack)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mk_pkt(input logic [7:0] tag, input SeqNum seq);
    return {tag, 52'h0C0DE00000000, seq};
  endfunction

  function automatic void push_pkt(input int c, input logic [7:0] tag, input SeqNum seq);
    pkt_exp_t e;
    e.cyc  = c;
    e.data = mk_pkt(tag, seq);
    pkt_q.push_back(e);
  endfunction

  function automatic void push_hs(input int c, input logic is_ack, input SeqNum cnt);
    hs_exp_t e;
    e.cyc    = c;
    e.is_ack = is_ack;
    e.cnt    = cnt;
    hs_q.push_back(e);
  endfunction

  // Drives one cycle of inputs, then scores the registered outputs against
  // the expectation queues for the cycle just completed.
  task automatic apply_stimulus(input logic v, input SeqNum seq, input logic err,
                                input logic [7:0] tag, input logic rdy);
    logic  exp_ack;
    logic  exp_nack;
    SeqNum exp_cnt;
    rx_valid  = v;
    rx_seq    = seq;
    rx_error  = err;
    rx_packet = mk_pkt(tag, seq);
    out_ready = rdy;
    @(posedge clk);
    #1;
    cyc++;
    if (pkt_q.size() > 0 && pkt_q[0].cyc == cyc) begin
      mon_v = 1'b1;
      mon_d = pkt_q[0].data;
      void'(pkt_q.pop_front());
    end else if (nreset || rdy) begin
      mon_v = 1'b0;
    end
    checks++;
    if (out_valid !== mon_v || (mon_v && out_packet !== mon_d)) begin
      errors++;
      $display("[TB] FAIL output cyc %0d: valid=%b data=%h, want valid=%b data=%h",
               cyc, out_valid, out_packet, mon_v, mon_d);
    end
    exp_ack  = 1'b0;
    exp_nack = 1'b0;
    exp_cnt  = '0;
    if (hs_q.size() > 0 && hs_q[0].cyc == cyc) begin
      exp_ack  = hs_q[0].is_ack;
      exp_nack = !hs_q[0].is_ack;
      exp_cnt  = hs_q[0].is_ack ? hs_q[0].cnt : '0;
      void'(hs_q.pop_front());
    end
    checks++;
    if (ack !== exp_ack || ack_count !== exp_cnt || nack !== exp_nack) begin
      errors++;
      $display("[TB] FAIL handshake cyc %0d: ack=%b count=%0d nack=%b, want ack=%b count=%0d nack=%b",
               cyc, ack, ack_count, nack, exp_ack, exp_cnt, exp_nack);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    pkt_q.delete();
    hs_q.delete();
    nreset = 1'b1;
    apply_stimulus(1'b0, '0, 1'b0, 8'h00, 1'b1);
    nreset = 1'b0;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (pkt_q.size() != 0 || hs_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s drain: %0d packets and %0d acks/nacks still outstanding, want 0",
               name, pkt_q.size(), hs_q.size());
    end
  endtask

  task automatic test_reset();
    int t0;
    do_reset();
    checks++;
    if ({out_valid, ack, nack} !== 3'b000 || out_packet !== '0 || ack_count !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: valid=%b data=%h ack=%b count=%0d nack=%b, want all 0",
               out_valid, out_packet, ack, ack_count, nack);
    end
    t0 = cyc;
    push_pkt(t0 + 1, 8'h01, 4'd0);
    apply_stimulus(1'b1, 4'd0, 1'b0, 8'h01, 1'b1);
    nreset = 1'b1;
    apply_stimulus(1'b1, 4'd1, 1'b0, 8'h01, 1'b1);
    nreset = 1'b0;
    checks++;
    if ({out_valid, ack, nack} !== 3'b000 || out_packet !== '0 || ack_count !== '0) begin
      errors++;
      $display("[TB] FAIL reset_midstream: valid=%b data=%h ack=%b count=%0d nack=%b, want all 0",
               out_valid, out_packet, ack, ack_count, nack);
    end
    push_pkt(cyc + 1, 8'h02, 4'd0);
    apply_stimulus(1'b1, 4'd0, 1'b0, 8'h02, 1'b1);
    idle(2);
    check_drained("test_reset");
  endtask

  task automatic test_in_order();
    int t0;
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      push_pkt(t0 + i + 1, 8'h10, SeqNum'(i));
      if (i == 3 || i == 7) push_hs(t0 + i + 1, 1'b1, 4'd4);
      apply_stimulus(1'b1, SeqNum'(i), 1'b0, 8'h10, 1'b1);
    end
    idle(3);
    check_drained("test_in_order");
  endtask

  task automatic test_idle_ack();
    int t0;
    do_reset();
    t0 = cyc;
    push_pkt(t0 + 1, 8'h20, 4'd0);
    push_pkt(t0 + 2, 8'h20, 4'd1);
    push_hs(t0 + 34, 1'b1, 4'd2);
    apply_stimulus(1'b1, 4'd0, 1'b0, 8'h20, 1'b1);
    apply_stimulus(1'b1, 4'd1, 1'b0, 8'h20, 1'b1);
    idle(36);
    check_drained("test_idle_ack");
  endtask

  task automatic test_error_recovery();
    int t0;
    do_reset();
    t0 = cyc;
    push_pkt(t0 + 1, 8'h30, 4'd0);
    push_pkt(t0 + 2, 8'h30, 4'd1);
    push_hs(t0 + 3, 1'b1, 4'd2);
    push_hs(t0 + 4, 1'b0, 4'd0);
    push_pkt(t0 + 6, 8'h31, 4'd2);
    push_pkt(t0 + 7, 8'h31, 4'd3);
    push_hs(t0 + 8, 1'b1, 4'd2);
    push_hs(t0 + 9, 1'b0, 4'd0);
    apply_stimulus(1'b1, 4'd0, 1'b0, 8'h30, 1'b1);
    apply_stimulus(1'b1, 4'd1, 1'b0, 8'h30, 1'b1);
    apply_stimulus(1'b1, 4'd2, 1'b1, 8'h3E, 1'b1);
    apply_stimulus(1'b1, 4'd3, 1'b0, 8'h3D, 1'b1);
    apply_stimulus(1'b1, 4'd4, 1'b0, 8'h3D, 1'b1);
    apply_stimulus(1'b1, 4'd2, 1'b0, 8'h31, 1'b1);
    apply_stimulus(1'b1, 4'd3, 1'b0, 8'h31, 1'b1);
    apply_stimulus(1'b1, 4'd9, 1'b0, 8'h3D, 1'b1);
    idle(3);
    check_drained("test_error_recovery");
  endtask

  task automatic test_wrong_seq_timeout();
    int t0;
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      push_pkt(t0 + i + 1, 8'h40, SeqNum'(i));
      if (i == 3) push_hs(t0 + 4, 1'b1, 4'd4);
      apply_stimulus(1'b1, SeqNum'(i), 1'b0, 8'h40, 1'b1);
    end
    push_hs(t0 + 5, 1'b0, 4'd0);
    push_hs(t0 + 69, 1'b0, 4'd0);
    apply_stimulus(1'b1, 4'd6, 1'b0, 8'h4D, 1'b1);
    for (int i = 5; i < 72; i++) begin
      apply_stimulus((i == 20) || (i == 40), 4'd9, 1'b0, 8'h4D, 1'b1);
    end
    push_pkt(cyc + 1, 8'h41, 4'd4);
    apply_stimulus(1'b1, 4'd4, 1'b0, 8'h41, 1'b1);
    idle(1);
    check_drained("test_wrong_seq_timeout");
  endtask

  task automatic test_backpressure();
    int t0;
    do_reset();
    t0 = cyc;
    push_pkt(t0 + 1, 8'h50, 4'd0);
    push_hs(t0 + 3, 1'b1, 4'd1);
    push_hs(t0 + 4, 1'b0, 4'd0);
    apply_stimulus(1'b1, 4'd0, 1'b0, 8'h50, 1'b1);
    apply_stimulus(1'b0, 4'd0, 1'b0, 8'h00, 1'b0);
    apply_stimulus(1'b1, 4'd1, 1'b0, 8'h5E, 1'b0);
    apply_stimulus(1'b1, 4'd1, 1'b0, 8'h5E, 1'b0);
    apply_stimulus(1'b0, 4'd0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_packet !== mk_pkt(8'h50, 4'd0)) begin
      errors++;
      $display("[TB] FAIL held_packet: valid=%b data=%h, want valid=1 data=%h",
               out_valid, out_packet, mk_pkt(8'h50, 4'd0));
    end
    apply_stimulus(1'b0, 4'd0, 1'b0, 8'h00, 1'b0);
    apply_stimulus(1'b0, 4'd0, 1'b0, 8'h00, 1'b1);
    push_pkt(t0 + 8, 8'h51, 4'd1);
    push_pkt(t0 + 9, 8'h51, 4'd2);
    apply_stimulus(1'b1, 4'd1, 1'b0, 8'h51, 1'b1);
    apply_stimulus(1'b1, 4'd2, 1'b0, 8'h51, 1'b1);
    idle(3);
    check_drained("test_backpressure");
  endtask

  task automatic test_wrap_reset();
    int t0;
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 18; i++) begin
      push_pkt(t0 + i + 1, (i < 14) ? 8'h60 : 8'h61, SeqNum'(i));
      if (i == 3 || i == 7 || i == 11 || i == 15) push_hs(t0 + i + 1, 1'b1, 4'd4);
      apply_stimulus(1'b1, SeqNum'(i), 1'b0, (i < 14) ? 8'h60 : 8'h61, 1'b1);
    end
    nreset = 1'b1;
    apply_stimulus(1'b1, 4'd2, 1'b0, 8'h61, 1'b1);
    nreset = 1'b0;
    checks++;
    if ({out_valid, ack, nack} !== 3'b000 || out_packet !== '0 || ack_count !== '0) begin
      errors++;
      $display("[TB] FAIL wrap_reset_outputs: valid=%b data=%h ack=%b count=%0d nack=%b, want all 0",
               out_valid, out_packet, ack, ack_count, nack);
    end
    push_pkt(t0 + 20, 8'h62, 4'd0);
    push_pkt(t0 + 21, 8'h62, 4'd1);
    apply_stimulus(1'b1, 4'd0, 1'b0, 8'h62, 1'b1);
    apply_stimulus(1'b1, 4'd1, 1'b0, 8'h62, 1'b1);
    idle(3);
    check_drained("test_wrap_reset");
  endtask

  // Scenario sequence
  initial begin
    $display("[TB] replay_receiver bench start");
    test_reset();
    test_in_order();
    test_idle_ack();
    test_error_recovery();
    test_wrong_seq_timeout();
    test_backpressure();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
